// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl
//   Four-digit ID entry sequencer. Debounced toggle/enter button levels are
//   edge-detected; toggle steps the current digit value (wrapping past
//   DIGIT_MAX), enter commits it into EntryBus and advances the position.
//   After the fourth digit the entry is compared against CODE: a match opens,
//   a mismatch flags an error, and MAX_TRIES consecutive mismatches force a
//   LOCK_CYCLES-long lockout during which all buttons are ignored.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous, active-low reset
//   ToggleBtn   in   debounced toggle button level, active-high
//   EnterBtn    in   debounced enter button level, active-high
//   DigitPos    out  index of digit being entered (0..3)
//   DigitValue  out  current value of digit being entered
//   EntryBus    out  committed digits; pos 0 in [15:12], pos 3 in [3:0]
//   Unlocked    out  high while open
//   ErrorFlag   out  high after a mismatch, until enter is pressed
//   Locked      out  high during lockout
//   FailCount   out  consecutive mismatches (low 2 bits)

module digit_entry_ctrl #(
   parameter logic [15:0] CODE        = 16'h1234,
   parameter int unsigned DIGIT_MAX   = 9,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCK_CYCLES = 1000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ToggleBtn,
   input  logic        EnterBtn,
   output logic [1:0]  DigitPos,
   output logic [3:0]  DigitValue,
   output logic [15:0] EntryBus,
   output logic        Unlocked,
   output logic        ErrorFlag,
   output logic        Locked,
   output logic [1:0]  FailCount
);

   localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam int unsigned FW = ($clog2(MAX_TRIES + 1) > 2) ? $clog2(MAX_TRIES + 1) : 2;
   localparam logic [3:0]    DMAX  = 4'(DIGIT_MAX);
   localparam logic [TW-1:0] TLAST = TW'(LOCK_CYCLES - 1);
   localparam logic [FW-1:0] FMAX  = FW'(MAX_TRIES);

   typedef enum logic [2:0] {
      ENTER,
      CHECK,
      OPEN,
      FAIL,
      LOCKOUT
   } stateT;

   stateT         state, stateN;
   logic [1:0]    pos, posN;
   logic [3:0]    val, valN;
   logic [15:0]   bus, busN;
   logic [FW-1:0] fails, failsN, failsInc;
   logic [TW-1:0] timer, timerN;
   logic          togHist, entHist;
   logic          togEdge, entEdge;
   logic          unlockedQ, errorQ, lockedQ;

   assign togEdge  = ToggleBtn & ~togHist;
   assign entEdge  = EnterBtn & ~entHist;
   assign failsInc = fails + 1'b1;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state     <= ENTER;
         pos       <= '0;
         val       <= '0;
         bus       <= '0;
         fails     <= '0;
         timer     <= '0;
         togHist   <= 1'b0;
         entHist   <= 1'b0;
         unlockedQ <= 1'b0;
         errorQ    <= 1'b0;
         lockedQ   <= 1'b0;
      end else begin
         state     <= stateN;
         pos       <= posN;
         val       <= valN;
         bus       <= busN;
         fails     <= failsN;
         timer     <= timerN;
         togHist   <= ToggleBtn;
         entHist   <= EnterBtn;
         // status is registered from the next state so it tracks state exactly
         unlockedQ <= (stateN == OPEN);
         errorQ    <= (stateN == FAIL);
         lockedQ   <= (stateN == LOCKOUT);
      end
   end

   always_comb begin
      stateN = state;
      posN   = pos;
      valN   = val;
      busN   = bus;
      failsN = fails;
      timerN = timer;

      case (state)
         ENTER: begin
            // enter has priority: a coincident toggle is dropped
            if (entEdge) begin
               case (pos)
                  2'd0: busN[15:12] = val;
                  2'd1: busN[11:8]  = val;
                  2'd2: busN[7:4]   = val;
                  2'd3: busN[3:0]   = val;
               endcase
               valN = '0;
               if (pos == 2'd3) begin
                  stateN = CHECK;
               end else begin
                  posN = pos + 2'd1;
               end
            end else if (togEdge) begin
               valN = (val == DMAX) ? '0 : val + 4'd1;
            end
         end

         CHECK: begin
            if (bus == CODE) begin
               stateN = OPEN;
               failsN = '0;
            end else begin
               failsN = (fails >= FMAX) ? FMAX : failsInc;
               if (failsInc == FMAX) begin
                  stateN = LOCKOUT;
                  timerN = '0;
               end else begin
                  stateN = FAIL;
               end
            end
         end

         OPEN, FAIL: begin
            if (entEdge) begin
               stateN = ENTER;
               posN   = '0;
               valN   = '0;
               busN   = '0;
            end
         end

         LOCKOUT: begin
            if (timer == TLAST) begin
               stateN = ENTER;
               failsN = '0;
               timerN = '0;
               posN   = '0;
               valN   = '0;
               busN   = '0;
            end else begin
               timerN = timer + 1'b1;
            end
         end

         default: stateN = ENTER;
      endcase
   end

   assign DigitPos   = pos;
   assign DigitValue = val;
   assign EntryBus   = bus;
   assign Unlocked   = unlockedQ;
   assign ErrorFlag  = errorQ;
   assign Locked     = lockedQ;
   assign FailCount  = fails[1:0];

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl: a vector table for the basic entry,
// wrap-around, held-button and simultaneous-edge behaviour, followed by
// hand-written sequences for failure, lockout and mid-operation reset.

module tb_digit_entry_ctrl;

   logic        Clk;
   logic        Reset;
   logic        ToggleBtn;
   logic        EnterBtn;
   logic [1:0]  DigitPos;
   logic [3:0]  DigitValue;
   logic [15:0] EntryBus;
   logic        Unlocked;
   logic        ErrorFlag;
   logic        Locked;
   logic [1:0]  FailCount;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic        tog;
      logic        ent;
      logic [1:0]  pos;
      logic [3:0]  val;
      logic [15:0] bus;
      logic        unl;
      logic        err;
      logic        lck;
      logic [1:0]  fc;
   } vecT;

   vecT vecs[$];

   digit_entry_ctrl #(
      .CODE(16'h1234),
      .DIGIT_MAX(9),
      .MAX_TRIES(3),
      .LOCK_CYCLES(16)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .ToggleBtn(ToggleBtn),
      .EnterBtn(EnterBtn),
      .DigitPos(DigitPos),
      .DigitValue(DigitValue),
      .EntryBus(EntryBus),
      .Unlocked(Unlocked),
      .ErrorFlag(ErrorFlag),
      .Locked(Locked),
      .FailCount(FailCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic addVec(input logic t, input logic e, input logic [1:0] p,
                         input logic [3:0] v, input logic [15:0] b,
                         input logic u, input logic er, input logic l,
                         input logic [1:0] f);
      vecT x;
      x.tog = t; x.ent = e; x.pos = p; x.val = v; x.bus = b;
      x.unl = u; x.err = er; x.lck = l; x.fc = f;
      vecs.push_back(x);
   endtask

   // drive buttons, let one rising edge pass, sample 1 time unit later
   task automatic step(input logic t, input logic e);
      ToggleBtn = t;
      EnterBtn  = e;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkAll(input string name, input logic [1:0] p,
                           input logic [3:0] v, input logic [15:0] b,
                           input logic u, input logic er, input logic l,
                           input logic [1:0] f);
      logic [26:0] act, exp;
      act = {DigitPos, DigitValue, EntryBus, Unlocked, ErrorFlag, Locked, FailCount};
      exp = {p, v, b, u, er, l, f};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got pos=%0d val=%0d bus=%h unl=%b err=%b lck=%b fc=%0d, want pos=%0d val=%0d bus=%h unl=%b err=%b lck=%b fc=%0d",
                  name, DigitPos, DigitValue, EntryBus, Unlocked, ErrorFlag, Locked,
                  FailCount, p, v, b, u, er, l, f);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic doReset();
      ToggleBtn = 1'b0;
      EnterBtn  = 1'b0;
      Reset     = 1'b0;
      @(posedge Clk);
      #1;
      Reset = 1'b1;
   endtask

   // enters four digits from a clean ENTER state: N toggles then one enter each
   task automatic enterCode(input logic [15:0] code);
      logic [3:0] nib;
      for (int d = 0; d < 4; d++) begin
         nib = code[15 - 4*d -: 4];
         for (int k = 0; k < int'(nib); k++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
         end
         step(1'b0, 1'b1);
         step(1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [15:0] b;
      logic [3:0]  nib;
      int          lockCnt;

      Reset     = 1'b0;
      ToggleBtn = 1'b0;
      EnterBtn  = 1'b0;

      // ---- build vector table ----
      // correct code 1,2,3,4
      b = 16'h0000;
      for (int d = 0; d < 4; d++) begin
         nib = 4'(d + 1);
         for (int k = 1; k <= int'(nib); k++) begin
            addVec(1, 0, 2'(d), 4'(k), b, 0, 0, 0, 0);
            addVec(0, 0, 2'(d), 4'(k), b, 0, 0, 0, 0);
         end
         b[15 - 4*d -: 4] = nib;
         addVec(0, 1, (d == 3) ? 2'd3 : 2'(d + 1), 4'd0, b, 0, 0, 0, 0);
      end
      addVec(0, 0, 3, 0, 16'h1234, 1, 0, 0, 0);   // 2 cycles after last enter
      addVec(0, 0, 3, 0, 16'h1234, 1, 0, 0, 0);
      addVec(1, 0, 3, 0, 16'h1234, 1, 0, 0, 0);   // toggle ignored when open
      addVec(0, 0, 3, 0, 16'h1234, 1, 0, 0, 0);
      addVec(0, 1, 0, 0, 16'h0000, 0, 0, 0, 0);   // enter back to ENTER
      addVec(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
      // wrap: 11 toggles -> 1..9,0,1
      for (int i = 1; i <= 11; i++) begin
         addVec(1, 0, 0, (i <= 9) ? 4'(i) : 4'(i - 10), 0, 0, 0, 0, 0);
         addVec(0, 0, 0, (i <= 9) ? 4'(i) : 4'(i - 10), 0, 0, 0, 0, 0);
      end
      // held toggle for 20 cycles -> single increment
      for (int i = 0; i < 20; i++) addVec(1, 0, 0, 2, 0, 0, 0, 0, 0);
      addVec(0, 0, 0, 2, 0, 0, 0, 0, 0);
      // step to 5, then coincident toggle + enter
      for (int i = 3; i <= 5; i++) begin
         addVec(1, 0, 0, 4'(i), 0, 0, 0, 0, 0);
         addVec(0, 0, 0, 4'(i), 0, 0, 0, 0, 0);
      end
      addVec(1, 1, 1, 0, 16'h5000, 0, 0, 0, 0);
      addVec(0, 0, 1, 0, 16'h5000, 0, 0, 0, 0);

      // ---- reset and apply table ----
      repeat (2) @(posedge Clk);
      #1;
      checkAll("reset_state", 0, 0, 16'h0000, 0, 0, 0, 0);
      Reset = 1'b1;
      foreach (vecs[i]) begin
         step(vecs[i].tog, vecs[i].ent);
         checkAll($sformatf("vec%0d", i), vecs[i].pos, vecs[i].val, vecs[i].bus,
                  vecs[i].unl, vecs[i].err, vecs[i].lck, vecs[i].fc);
      end

      // ---- failure path ----
      doReset();
      checkAll("reset_before_fail", 0, 0, 16'h0000, 0, 0, 0, 0);
      enterCode(16'h0000);
      checkAll("fail_0000", 3, 0, 16'h0000, 0, 1, 0, 1);
      step(1'b0, 1'b1);
      checkAll("fail_exit", 0, 0, 16'h0000, 0, 0, 0, 1);
      step(1'b0, 1'b0);
      enterCode(16'h1234);
      checkAll("open_after_fail", 3, 0, 16'h1234, 1, 0, 0, 0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // ---- lockout ----
      enterCode(16'h0000);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      enterCode(16'h0100);
      checkAll("second_fail", 3, 0, 16'h0100, 0, 1, 0, 2);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      enterCode(16'h0000);
      checkAll("lockout_entry", 3, 0, 16'h0000, 0, 0, 1, 3);
      lockCnt = 1;
      for (int i = 0; i < 40; i++) begin
         step(1'(i), 1'(i >> 1));
         if (!Locked) break;
         lockCnt++;
      end
      checkInt("lockout_cycles", lockCnt, 16);
      checkAll("lockout_exit", 0, 0, 16'h0000, 0, 0, 0, 0);
      step(1'b0, 1'b0);
      checkAll("after_lockout_idle", 0, 0, 16'h0000, 0, 0, 0, 0);
      step(1'b1, 1'b0);
      checkAll("after_lockout_toggle", 0, 1, 16'h0000, 0, 0, 0, 0);
      step(1'b0, 1'b0);

      // ---- reset during digit 2 entry ----
      doReset();
      step(1'b1, 1'b0); step(1'b0, 1'b0);
      step(1'b0, 1'b1); step(1'b0, 1'b0);
      step(1'b1, 1'b0); step(1'b0, 1'b0);
      step(1'b1, 1'b0); step(1'b0, 1'b0);
      checkAll("mid_entry", 1, 2, 16'h1000, 0, 0, 0, 0);
      doReset();
      checkAll("reset_mid_entry", 0, 0, 16'h0000, 0, 0, 0, 0);
      enterCode(16'h1234);
      checkAll("open_after_reset1", 3, 0, 16'h1234, 1, 0, 0, 0);

      // ---- reset during lockout ----
      doReset();
      for (int n = 0; n < 3; n++) begin
         enterCode(16'h0000);
         if (n < 2) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
         end
      end
      repeat (4) step(1'b0, 1'b0);
      checkAll("in_lockout", 3, 0, 16'h0000, 0, 0, 1, 3);
      doReset();
      checkAll("reset_mid_lockout", 0, 0, 16'h0000, 0, 0, 0, 0);
      enterCode(16'h1234);
      checkAll("open_after_reset2", 3, 0, 16'h1234, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
